// File: rtl/control_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// control_fsm : multi-cycle RV32I control sequencer with handshaken memory.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module control_fsm #(
    parameter int W       = 32,
    parameter int CNT_W   = 32,
    parameter int TRAP_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     instr,
    input  logic             flag,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             RegWrite,
    output logic             RamWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic [2:0]       IMMsrc,
    output logic [1:0]       ResultSrc,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEMADR    = 4'd2;
    localparam logic [3:0] S_MEMREAD   = 4'd3;
    localparam logic [3:0] S_MEMWB     = 4'd4;
    localparam logic [3:0] S_MEMWRITE  = 4'd5;
    localparam logic [3:0] S_EXECR     = 4'd6;
    localparam logic [3:0] S_EXECI     = 4'd7;
    localparam logic [3:0] S_ALUWB     = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_JALR      = 4'd11;
    localparam logic [3:0] S_JALR_LINK = 4'd12;
    localparam logic [3:0] S_LUI       = 4'd13;
    localparam logic [3:0] S_AUIPC     = 4'd14;
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [6:0]       opcode;
    logic             ir_wr, pc_wr, reg_wr, ram_wr;
    logic             w_unused_instr;

    assign opcode         = instr[6:0];
    assign w_unused_instr = &{1'b0, instr[W-1:7]};

    always_comb begin
        IMMsrc = 3'b000;
        case (opcode)
            OP_I, OP_LOAD, OP_JALR: IMMsrc = 3'b000;
            OP_STORE:               IMMsrc = 3'b001;
            OP_BRANCH:              IMMsrc = 3'b010;
            OP_LUI, OP_AUIPC:       IMMsrc = 3'b011;
            OP_JAL:                 IMMsrc = 3'b100;
            default:                IMMsrc = 3'b000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        reg_wr    = 1'b0;
        ram_wr    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUop     = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_wr    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                ram_wr = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUop   = 2'b01;
                pc_wr   = flag;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pc_wr   = 1'b1;
                state_d = S_ALUWB;
            end
            // Target computed from rs1 before the link write, so rd==rs1 is safe
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ALUop     = 2'b11;
                ResultSrc = 2'b10;
                pc_wr     = 1'b1;
                state_d   = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                reg_wr    = 1'b1;
                state_d   = S_FETCH;
            end
            S_LUI: begin
                ResultSrc = 2'b11;
                reg_wr    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        instret_d = instret_q;
        if ((state_q != S_FETCH) && (state_d == S_FETCH)) instret_d = instret_q + C_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Strobes are held off while reset is asserted, even though FETCH would raise them
    assign IRWrite  = ir_wr  & rst_n;
    assign PCWrite  = pc_wr  & rst_n;
    assign RegWrite = reg_wr & rst_n;
    assign RamWrite = ram_wr & rst_n;
    assign state    = state_q;
    assign illegal  = (state_q == S_TRAP);
    assign instret  = instret_q;

endmodule
`default_nettype wire
